// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch-resolution constants and BHT index function
// Contents:
//   SNT/WNT/WT/STK  2-bit saturating counter encodings
//   INSTR_BYTES     instruction size in bytes (fallthrough step)
//   bht_index()     PC + table depth -> BHT index, shared by fetch lookup and EX update
package branch_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] STK = 2'b11;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned INSTR_SHIFT = $clog2(INSTR_BYTES);

  // Drops the byte offset inside an instruction, then keeps log2(depth) bits.
  // depth must be a power of two.
  function automatic int unsigned bht_index(input logic [63:0] pc, input int unsigned depth);
    logic [63:0] mask;
    mask = 64'(depth) - 64'd1;
    return 32'((pc >> INSTR_SHIFT) & mask);
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating branch history table
// Ports:
//   clk, rst          clock, synchronous active-high reset (all entries -> WNT)
//   rd_idx, rd_taken  combinational read port, rd_taken = counter[1] (pre-update value)
//   wr_en, wr_idx     synchronous update strobe and index
//   wr_taken          1: count up toward STK, 0: count down toward SNT
module branch_history_table
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (wr_en) begin
      if (wr_taken) begin
        if (ctr_q[wr_idx] != STK) begin
          ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
        end
      end else begin
        if (ctr_q[wr_idx] != SNT) begin
          ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
        end
      end
    end
  end

  // Reads the registered array, so a same-cycle write to rd_idx is not seen
  // until the next cycle.
  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution, redirect/flush and BHT owner
// Optional feature macro: BRANCH_STATS_EN (resolved / mispredicted branch counters)
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   STALL                       blocks resolution and BHT update
//   BR_VALID, BR_PC, BR_OFFSET  branch in EX, its PC and sign-extended immediate
//   COMP_OUT                    comparator outcome (1 = taken)
//   PRED_TAKEN, PRED_TARGET     fetch-time prediction for this branch
//   FETCH_PC, FETCH_PRED_TAKEN  BHT lookup address and its taken prediction
//   REDIRECT, REDIRECT_PC       one-cycle redirect pulse and corrected PC
//   FLUSH                       one-cycle squash of IF/ID and the EX slot
//   BR_COUNT, MISPRED_COUNT     saturating statistics, 0 when BRANCH_STATS_EN is undefined
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BHT_DEPTH  = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  STALL,
  input  logic                  BR_VALID,
  input  logic [ADDR_WIDTH-1:0] BR_PC,
  input  logic [31:0]           BR_OFFSET,
  input  logic                  COMP_OUT,
  input  logic                  PRED_TAKEN,
  input  logic [ADDR_WIDTH-1:0] PRED_TARGET,
  input  logic [ADDR_WIDTH-1:0] FETCH_PC,
  output logic                  FETCH_PRED_TAKEN,
  output logic                  REDIRECT,
  output logic [ADDR_WIDTH-1:0] REDIRECT_PC,
  output logic                  FLUSH,
  output logic [31:0]           BR_COUNT,
  output logic [31:0]           MISPRED_COUNT
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic                  redirect_q;
  logic [ADDR_WIDTH-1:0] redirect_pc_q;

  logic                  resolve;
  logic                  taken;
  logic                  mispred;
  logic [ADDR_WIDTH-1:0] offset_ext;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] fallthrough;
  logic [IDX_W-1:0]      fetch_idx;
  logic [IDX_W-1:0]      br_idx;

  // A branch sitting in EX while FLUSH is high is itself being squashed.
  assign resolve = BR_VALID & ~STALL & ~redirect_q;
  assign taken   = COMP_OUT;

  // Sign-extend (or truncate) the 32-bit immediate to the address width;
  // sums wrap modulo 2^ADDR_WIDTH.
  assign offset_ext  = ADDR_WIDTH'($signed(BR_OFFSET));
  assign target      = BR_PC + offset_ext;
  assign fallthrough = BR_PC + ADDR_WIDTH'(INSTR_BYTES);

  assign mispred = (taken != PRED_TAKEN) | (taken & (PRED_TARGET != target));

  always_ff @(posedge CLK) begin
    if (RST) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      // Pulse never stretches: recomputed every cycle, and the shadow gate in
      // resolve forces it low the cycle after it fires.
      redirect_q <= resolve & mispred;
      if (resolve & mispred) begin
        redirect_pc_q <= taken ? target : fallthrough;
      end
    end
  end

  assign REDIRECT    = redirect_q;
  assign FLUSH       = redirect_q;
  assign REDIRECT_PC = redirect_pc_q;

  assign fetch_idx = IDX_W'(bht_index(64'(FETCH_PC), BHT_DEPTH));
  assign br_idx    = IDX_W'(bht_index(64'(BR_PC), BHT_DEPTH));

  branch_history_table #(
    .DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk      (CLK),
    .rst      (RST),
    .rd_idx   (fetch_idx),
    .rd_taken (FETCH_PRED_TAKEN),
    .wr_en    (resolve),
    .wr_idx   (br_idx),
    .wr_taken (taken)
  );

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q;
  logic [31:0] mispred_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else if (resolve) begin
      if (br_count_q != 32'hFFFF_FFFF) begin
        br_count_q <= br_count_q + 32'd1;
      end
      if (mispred && (mispred_count_q != 32'hFFFF_FFFF)) begin
        mispred_count_q <= mispred_count_q + 32'd1;
      end
    end
  end

  assign BR_COUNT      = br_count_q;
  assign MISPRED_COUNT = mispred_count_q;
`else
  assign BR_COUNT      = 32'd0;
  assign MISPRED_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

`ifdef BRANCH_STATS_EN
  localparam bit STATS_BUILT = 1'b1;
`else
  localparam bit STATS_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        comp_out;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] fetch_pc;
  logic        fetch_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int          bht_m [64];
  bit          exp_redirect;
  logic [31:0] exp_rpc;
  longint      exp_br_cnt;
  longint      exp_mis_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .ADDR_WIDTH (32),
    .BHT_DEPTH  (64)
  ) dut (
    .CLK              (clk),
    .RST              (rst),
    .STALL            (stall),
    .BR_VALID         (br_valid),
    .BR_PC            (br_pc),
    .BR_OFFSET        (br_offset),
    .COMP_OUT         (comp_out),
    .PRED_TAKEN       (pred_taken),
    .PRED_TARGET      (pred_target),
    .FETCH_PC         (fetch_pc),
    .FETCH_PRED_TAKEN (fetch_pred_taken),
    .REDIRECT         (redirect),
    .REDIRECT_PC      (redirect_pc),
    .FLUSH            (flush),
    .BR_COUNT         (br_count),
    .MISPRED_COUNT    (mispred_count)
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return bht_m[idx_of(pc)] >= 2;
  endfunction

  // Advances the model by one clock using the inputs currently applied, then
  // crosses the rising edge and settles 1 ns after it.
  task automatic tick();
    bit          resolve;
    bit          mis;
    logic [31:0] tgt;
    int          i;
    resolve = br_valid && !stall && !exp_redirect;
    tgt     = br_pc + br_offset;
    mis     = (comp_out != pred_taken) || (comp_out && (pred_target != tgt));
    if (rst) begin
      foreach (bht_m[k]) bht_m[k] = 1;
      exp_redirect = 1'b0;
      exp_rpc      = 32'd0;
      exp_br_cnt   = 0;
      exp_mis_cnt  = 0;
    end else begin
      exp_redirect = resolve && mis;
      if (resolve) begin
        i = idx_of(br_pc);
        if (comp_out) bht_m[i] = (bht_m[i] == 3) ? 3 : bht_m[i] + 1;
        else          bht_m[i] = (bht_m[i] == 0) ? 0 : bht_m[i] - 1;
        if (exp_br_cnt < 64'hFFFF_FFFF) exp_br_cnt++;
        if (mis && exp_mis_cnt < 64'hFFFF_FFFF) exp_mis_cnt++;
        if (mis) exp_rpc = comp_out ? tgt : br_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst         = 1'b0;
    stall       = 1'b0;
    br_valid    = 1'b0;
    br_pc       = 32'd0;
    br_offset   = 32'd0;
    comp_out    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    fetch_pc    = 32'd0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL reset_redirect: got %b want 0", redirect); end
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b want 0", flush); end
    vectors++; if (redirect_pc !== 32'd0) begin miscompares++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
    vectors++; if (br_count !== 32'd0) begin miscompares++; $display("FAIL reset_br_count: got %0d want 0", br_count); end
    vectors++; if (mispred_count !== 32'd0) begin miscompares++; $display("FAIL reset_mis_count: got %0d want 0", mispred_count); end
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i * 4);
      #1;
      vectors++;
      if (fetch_pred_taken !== 1'b0) begin
        miscompares++; $display("FAIL reset_bht[%0d]: got %b want 0 (WNT)", i, fetch_pred_taken);
      end
    end
  endtask

  task automatic test_mispredict_redirect();
    do_reset();
    br_valid = 1'b1; br_pc = 32'h100; br_offset = 32'h20; comp_out = 1'b1; pred_taken = 1'b0;
    fetch_pc = 32'h100;
    tick();
    br_valid = 1'b0;
    vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL mis_redirect: got %b want 1", redirect); end
    vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL mis_flush: got %b want 1", flush); end
    vectors++; if (redirect_pc !== 32'h120) begin miscompares++; $display("FAIL mis_rpc: got %h want 120", redirect_pc); end
    vectors++; if (fetch_pred_taken !== 1'b1) begin miscompares++; $display("FAIL mis_bht0: got %b want 1 (WT)", fetch_pred_taken); end
    tick();
    vectors++; if (redirect !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL mis_pulse_width: got redirect %b flush %b want 0 0", redirect, flush); end
    vectors++; if (redirect_pc !== 32'h120) begin miscompares++; $display("FAIL mis_rpc_hold: got %h want 120", redirect_pc); end
  endtask

  task automatic test_correct_prediction();
    do_reset();
    br_valid = 1'b1; br_pc = 32'h200; br_offset = 32'd0; comp_out = 1'b0; pred_taken = 1'b0;
    fetch_pc = 32'h200;
    tick();
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL corr_redirect: got %b want 0", redirect); end
    vectors++; if (fetch_pred_taken !== 1'b0) begin miscompares++; $display("FAIL corr_bht: got %b want 0", fetch_pred_taken); end
    tick();
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL corr_redirect2: got %b want 0", redirect); end
    // Entry should sit at SNT; one taken brings it only to WNT.
    comp_out = 1'b1; pred_taken = 1'b1; pred_target = 32'h200;
    tick();
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL corr_taken_redirect: got %b want 0", redirect); end
    vectors++; if (fetch_pred_taken !== 1'b0) begin miscompares++; $display("FAIL sat_low: got %b want 0", fetch_pred_taken); end
    tick();
    br_valid = 1'b0;
    vectors++; if (fetch_pred_taken !== 1'b1) begin miscompares++; $display("FAIL sat_recover: got %b want 1", fetch_pred_taken); end
    tick();
  endtask

  task automatic test_wrong_target();
    do_reset();
    br_valid = 1'b1; br_pc = 32'h300; br_offset = 32'h80; comp_out = 1'b1;
    pred_taken = 1'b1; pred_target = 32'h400;
    tick();
    br_valid = 1'b0;
    vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL wt_redirect: got %b want 1", redirect); end
    vectors++; if (redirect_pc !== 32'h380) begin miscompares++; $display("FAIL wt_rpc: got %h want 380", redirect_pc); end
    tick();
  endtask

  task automatic test_shadow();
    do_reset();
    br_valid = 1'b1; br_pc = 32'h100; br_offset = 32'h20; comp_out = 1'b1; pred_taken = 1'b0;
    tick();
    // Shadow branch: would mispredict and move entry 17 to WT if it resolved.
    br_pc = 32'h44; br_offset = 32'h40; comp_out = 1'b1; pred_taken = 1'b0;
    fetch_pc = 32'h44;
    tick();
    br_valid = 1'b0;
    vectors++; if (redirect !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL shadow_redirect: got redirect %b flush %b want 0 0", redirect, flush); end
    vectors++; if (redirect_pc !== 32'h120) begin miscompares++; $display("FAIL shadow_rpc: got %h want 120", redirect_pc); end
    vectors++; if (fetch_pred_taken !== 1'b0) begin miscompares++; $display("FAIL shadow_bht: got %b want 0", fetch_pred_taken); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1; br_valid = 1'b1; br_pc = 32'h500; br_offset = 32'h10; comp_out = 1'b1; pred_taken = 1'b0;
    fetch_pc = 32'h500;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL stall_redirect[%0d]: got %b want 0", c, redirect); end
      vectors++; if (fetch_pred_taken !== 1'b0) begin miscompares++; $display("FAIL stall_bht[%0d]: got %b want 0", c, fetch_pred_taken); end
    end
    stall = 1'b0;
    tick();
    br_valid = 1'b0;
    vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL stall_release: got %b want 1", redirect); end
    vectors++; if (redirect_pc !== 32'h510) begin miscompares++; $display("FAIL stall_rpc: got %h want 510", redirect_pc); end
    vectors++; if (fetch_pred_taken !== 1'b1) begin miscompares++; $display("FAIL stall_bht_upd: got %b want 1", fetch_pred_taken); end
    tick();
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL stall_single: got %b want 0", redirect); end
    vectors++; if (br_count !== (STATS_BUILT ? 32'd1 : 32'd0)) begin miscompares++; $display("FAIL stall_count: got %0d want %0d", br_count, STATS_BUILT ? 1 : 0); end
  endtask

  task automatic test_wrap();
    do_reset();
    br_valid = 1'b1; br_pc = 32'hFFFF_FFFC; br_offset = 32'h40; comp_out = 1'b0;
    pred_taken = 1'b1; pred_target = 32'h3C;
    tick();
    br_valid = 1'b0;
    vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL wrap_ft_redirect: got %b want 1", redirect); end
    vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_ft_rpc: got %h want 0", redirect_pc); end
    tick();
    br_valid = 1'b1; br_pc = 32'hFFFF_FFF0; br_offset = 32'h20; comp_out = 1'b1; pred_taken = 1'b0;
    tick();
    br_valid = 1'b0;
    vectors++; if (redirect_pc !== 32'h10) begin miscompares++; $display("FAIL wrap_tgt_rpc: got %h want 10", redirect_pc); end
    tick();
    br_valid = 1'b1; br_pc = 32'h800; br_offset = 32'hFFFF_FF00; comp_out = 1'b1; pred_taken = 1'b0;
    tick();
    br_valid = 1'b0;
    vectors++; if (redirect_pc !== 32'h700) begin miscompares++; $display("FAIL neg_offset_rpc: got %h want 700", redirect_pc); end
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    br_valid = 1'b1; br_pc = 32'h40; br_offset = 32'h8; comp_out = 1'b1;
    pred_taken = 1'b1; pred_target = 32'h48;
    fetch_pc = 32'h140;  // different PC, same index 16
    #1;
    vectors++; if (fetch_pred_taken !== 1'b0) begin miscompares++; $display("FAIL coll_pre_up: got %b want 0", fetch_pred_taken); end
    tick();
    vectors++; if (fetch_pred_taken !== 1'b1) begin miscompares++; $display("FAIL coll_post_up: got %b want 1", fetch_pred_taken); end
    comp_out = 1'b0; pred_taken = 1'b0;
    #1;
    vectors++; if (fetch_pred_taken !== 1'b1) begin miscompares++; $display("FAIL coll_pre_down: got %b want 1", fetch_pred_taken); end
    tick();
    br_valid = 1'b0;
    vectors++; if (fetch_pred_taken !== 1'b0) begin miscompares++; $display("FAIL coll_post_down: got %b want 0", fetch_pred_taken); end
    tick();
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      br_valid = 1'b1; br_pc = 32'h1000 + 32'(i * 8); br_offset = 32'h40;
      comp_out = (i == 2 || i == 5 || i == 8); pred_taken = 1'b0;
      tick();
      if (comp_out) begin
        br_valid = 1'b0;
        tick();
      end
    end
    br_valid = 1'b0;
    tick();
    vectors++; if (br_count !== (STATS_BUILT ? 32'd10 : 32'd0)) begin miscompares++; $display("FAIL stats_br: got %0d want %0d", br_count, STATS_BUILT ? 10 : 0); end
    vectors++; if (mispred_count !== (STATS_BUILT ? 32'd3 : 32'd0)) begin miscompares++; $display("FAIL stats_mis: got %0d want %0d", mispred_count, STATS_BUILT ? 3 : 0); end
    // Register a redirect, then reset on the cycle it is visible.
    br_valid = 1'b1; br_pc = 32'h2000; br_offset = 32'h40; comp_out = 1'b1; pred_taken = 1'b0;
    tick();
    br_valid = 1'b0;
    vectors++; if (redirect !== 1'b1) begin miscompares++; $display("FAIL stats_pre_rst_redirect: got %b want 1", redirect); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (redirect !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL rst_drop_redirect: got redirect %b flush %b want 0 0", redirect, flush); end
    vectors++; if (redirect_pc !== 32'd0) begin miscompares++; $display("FAIL rst_drop_rpc: got %h want 0", redirect_pc); end
    vectors++; if (br_count !== 32'd0 || mispred_count !== 32'd0) begin miscompares++; $display("FAIL rst_stats: got %0d/%0d want 0/0", br_count, mispred_count); end
    tick();
    vectors++; if (redirect !== 1'b0) begin miscompares++; $display("FAIL rst_no_late_redirect: got %b want 0", redirect); end
  endtask

  task automatic test_random();
    logic [31:0] want_bc;
    logic [31:0] want_mc;
    int          off;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 80) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      br_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) br_pc = 32'hFFFF_FF00 + 32'($urandom_range(0, 63) * 4);
      else                           br_pc = 32'($urandom_range(0, 511) * 4);
      off        = $urandom_range(0, 1023) * 2 - 1024;
      br_offset  = 32'(off);
      comp_out   = $urandom_range(0, 1) == 1;
      pred_taken = $urandom_range(0, 1) == 1;
      pred_target = ($urandom_range(0, 2) != 0) ? br_pc + br_offset : $urandom();
      fetch_pc   = ($urandom_range(0, 2) == 0) ? br_pc : 32'($urandom_range(0, 1023) * 4);
      #1;
      vectors++;
      if (fetch_pred_taken !== model_pred(fetch_pc)) begin
        miscompares++; $display("FAIL rnd_fetch_pred[%0d]: pc %h got %b want %b", n, fetch_pc, fetch_pred_taken, model_pred(fetch_pc));
      end
      tick();
      want_bc = STATS_BUILT ? 32'(exp_br_cnt) : 32'd0;
      want_mc = STATS_BUILT ? 32'(exp_mis_cnt) : 32'd0;
      vectors++;
      if (redirect !== exp_redirect || flush !== exp_redirect) begin
        miscompares++; $display("FAIL rnd_redirect[%0d]: got redirect %b flush %b want %b", n, redirect, flush, exp_redirect);
      end
      vectors++;
      if (redirect_pc !== exp_rpc) begin
        miscompares++; $display("FAIL rnd_rpc[%0d]: got %h want %h", n, redirect_pc, exp_rpc);
      end
      vectors++;
      if (br_count !== want_bc || mispred_count !== want_mc) begin
        miscompares++; $display("FAIL rnd_stats[%0d]: got %0d/%0d want %0d/%0d", n, br_count, mispred_count, want_bc, want_mc);
      end
    end
    set_idle();
    tick();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_mispredict_redirect();
    test_correct_prediction();
    test_wrong_target();
    test_shadow();
    test_stall();
    test_wrap();
    test_collision();
    test_stats();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolves conditional branches in EX, downstream of the branch comparator. Takes the comparator's 1-bit outcome together with the branch PC, immediate and fetch-time prediction. Detects mispredictions and issues a one-cycle PC redirect plus flush to fetch/decode. Owns the 2-bit saturating branch history table (BHT) that fetch reads for its taken/not-taken prediction.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC/address width
- BHT_DEPTH, 64, BHT entries; power of two, ≥ 4

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- STALL  in  1  pipeline stall; while high no branch is resolved and the BHT is not updated
- BR_VALID  in  1  conditional branch present in EX this cycle
- BR_PC  in  ADDR_WIDTH  PC of the branch in EX
- BR_OFFSET  in  32  sign-extended B-type immediate
- COMP_OUT  in  1  comparator result; 1 = condition true = taken
- PRED_TAKEN  in  1  direction predicted at fetch for this branch
- PRED_TARGET  in  ADDR_WIDTH  target fetch used if predicted taken
- FETCH_PC  in  ADDR_WIDTH  PC being fetched, BHT lookup address
- FETCH_PRED_TAKEN  out  1  BHT prediction for FETCH_PC, combinational from table state
- REDIRECT  out  1  one-cycle pulse: fetch must load REDIRECT_PC
- REDIRECT_PC  out  ADDR_WIDTH  corrected PC
- FLUSH  out  1  one-cycle pulse: squash IF/ID and the EX slot
- BR_COUNT  out  32  resolved-branch counter (see Configuration)
- MISPRED_COUNT  out  32  misprediction counter (see Configuration)

## Operation
- A branch is resolved when BR_VALID & ~STALL & ~FLUSH. A branch in EX during a FLUSH cycle is in the shadow: ignored, with no BHT update.
- On resolution:
  - taken = COMP_OUT
  - target = BR_PC + BR_OFFSET, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH)
  - fallthrough = BR_PC + 4, also wraps
- Mispredict = (taken != PRED_TAKEN) | (taken & PRED_TARGET != target).
- On mispredict, register REDIRECT=1, FLUSH=1 and REDIRECT_PC = taken ? target : fallthrough. Otherwise REDIRECT = FLUSH = 0.
- REDIRECT and FLUSH are high for exactly one cycle. They are never stretched by STALL. REDIRECT_PC holds its last value when REDIRECT is low.
- BHT indexing: index = PC[log2(BHT_DEPTH)+1:2]. The same function is used for FETCH_PC and BR_PC.
- BHT counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- BHT update: +1 on taken, −1 on not taken, saturating at 11 and 00. The update is written on the same edge that registers REDIRECT.
- FETCH_PRED_TAKEN = counter[1] of the indexed entry.
- Read/write to the same index in one cycle: FETCH_PRED_TAKEN shows the pre-update value (read-before-write).
- Reset: every BHT entry = 01. REDIRECT = 0, FLUSH = 0, REDIRECT_PC = 0, BR_COUNT = 0, MISPRED_COUNT = 0.
- Reset asserted while a redirect is registered: outputs are 0 on the next edge and the pending redirect is dropped.

## Timing
- Resolution cycle N (comparator output valid in N) → REDIRECT/FLUSH/REDIRECT_PC valid in cycle N+1. Latency is 1.
- BHT update becomes visible on FETCH_PRED_TAKEN from cycle N+1.
- Back-to-back branches: a branch in cycle N+1 is ignored when FLUSH is high in N+1. Otherwise it resolves normally, giving a one-branch-per-cycle throughput.
- STALL in cycle N blocks resolution in N. The branch is resolved in the first non-stalled cycle in which BR_VALID is still high.
- COMP_OUT, BR_* and PRED_* are sampled only in the resolving cycle. No path exists from them to any output in the same cycle.

## Configuration
- BRANCH_STATS_EN defined:
  - BR_COUNT increments on every resolution.
  - MISPRED_COUNT increments on every mispredict.
  - Both saturate at 32'hFFFFFFFF and clear on RST.
- BRANCH_STATS_EN undefined: counters are not built, and both ports are tied to 0.

## Structure
- Shared package branch_pkg holds:
  - counter encodings SNT/WNT/WT/STK (2-bit localparams)
  - INSTR_BYTES = 4
  - the BHT index function (PC, depth → index)
- One sub-module, branch_history_table:
  - BHT_DEPTH×2-bit register array
  - combinational read port for FETCH_PC
  - synchronous saturating update port
  - synchronous reset to WNT

## Test plan
- Reset, then BR_VALID=1, BR_PC=0x100, BR_OFFSET=0x20, COMP_OUT=1, PRED_TAKEN=0 → next cycle REDIRECT=1, FLUSH=1, REDIRECT_PC=0x120, BHT[0] 01→10; following cycle both pulses are 0.
- Correct prediction: BR_PC=0x200, COMP_OUT=0, PRED_TAKEN=0 → no REDIRECT; BHT entry 01→00. Repeat the not-taken branch → entry stays 00 (saturation).
- Wrong target: COMP_OUT=1, PRED_TAKEN=1, PRED_TARGET=0x400, computed target 0x380 → REDIRECT_PC=0x380.
- Shadow and stall:
  - Branch asserted in the FLUSH cycle → ignored: no second redirect, no BHT change.
  - STALL=1 with BR_VALID for 3 cycles, then STALL=0 → exactly one resolution, in the cycle after STALL falls.
- Wrap and collision:
  - BR_PC=0xFFFFFFFC, COMP_OUT=0, predicted taken → REDIRECT_PC=0x00000000.
  - Same cycle FETCH_PC index equals BR_PC index → FETCH_PRED_TAKEN shows the old counter.
- BRANCH_STATS_EN defined: 10 branches with 3 mispredicts → BR_COUNT=10, MISPRED_COUNT=3; RST mid-run → both 0. Undefined → both ports read 0 throughout.
